// File: rtl/aes_pkg.sv
// Shared AES definitions: key-size encodings, Nk/Nr lookup, round-key bus width, GF(2^8) xtime.
package aes_pkg;

    localparam int MAX_ROUNDS = 14;
    localparam int RK_W       = 128 * (MAX_ROUNDS + 1);

    typedef enum logic [1:0] {
        AES128   = 2'b00,
        AES192   = 2'b01,
        AES256   = 2'b10,
        AES_RSVD = 2'b11
    } key_size_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } kx_state_e;

    function automatic logic [3:0] nk_of(input logic [1:0] size);
        case (size)
            AES192:  return 4'd6;
            AES256:  return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] size);
        case (size)
            AES192:  return 4'd12;
            AES256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Handshake and round-key bus between the key expander and its consumers.
interface aes_key_expander_if;
    import aes_pkg::*;

    // start is a single-cycle request sampled on the rising edge; it is only
    // honoured while busy is low and size is not reserved, otherwise dropped.
    logic                start;
    logic [255:0]        key;
    logic [1:0]          size;
    logic                busy;
    logic                done;
    logic                keys_valid;
    logic [3:0]          nr;
    logic [RK_W-1:0]     round_keys;
    kx_state_e           state_dbg;

    modport master (
        output start, key, size,
        input  busy, done, keys_valid, nr, round_keys, state_dbg
    );

    modport slave (
        input  start, key, size,
        output busy, done, keys_valid, nr, round_keys, state_dbg
    );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    logic [7:0] w_x2, w_x3, w_x6, w_x7, w_x14, w_x15, w_x30, w_x31;
    logic [7:0] w_x62, w_x63, w_x126, w_x127, w_inv;

    // x^254 is the inverse for nonzero x and maps 0 to 0, as the S-box needs.
    always_comb begin
        w_x2   = gf_mul(i_in, i_in);
        w_x3   = gf_mul(w_x2, i_in);
        w_x6   = gf_mul(w_x3, w_x3);
        w_x7   = gf_mul(w_x6, i_in);
        w_x14  = gf_mul(w_x7, w_x7);
        w_x15  = gf_mul(w_x14, i_in);
        w_x30  = gf_mul(w_x15, w_x15);
        w_x31  = gf_mul(w_x30, i_in);
        w_x62  = gf_mul(w_x31, w_x31);
        w_x63  = gf_mul(w_x62, i_in);
        w_x126 = gf_mul(w_x63, w_x63);
        w_x127 = gf_mul(w_x126, i_in);
        w_inv  = gf_mul(w_x127, w_x127);
    end

    assign o_out = w_inv
                 ^ {w_inv[6:0], w_inv[7]}
                 ^ {w_inv[5:0], w_inv[7:6]}
                 ^ {w_inv[4:0], w_inv[7:5]}
                 ^ {w_inv[3:0], w_inv[7:4]}
                 ^ 8'h63;

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128/192/256 key schedule: one 32-bit word per clock into a registered round-key bus.
module aes_key_expander
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    aes_key_expander_if.slave  if_kx
);

    kx_state_e        r_state;
    kx_state_e        w_state_nxt;
    logic [3:0]       r_nk;
    logic [3:0]       r_nr;
    logic [3:0]       r_nr_out;
    logic [5:0]       r_i;
    logic [5:0]       r_last_i;
    logic [2:0]       r_wrap;
    logic [7:0]       r_rcon;
    logic [31:0]      r_win [8];
    logic [RK_W-1:0]  r_round_keys;
    logic             r_keys_valid;
    logic             r_done;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic             w_rcon_step;
    logic [3:0]       w_nk_req;
    logic [3:0]       w_nr_req;
    logic [31:0]      w_key_w [8];
    logic [31:0]      w_prev;
    logic [31:0]      w_old;
    logic [31:0]      w_sub_in;
    logic [31:0]      w_sub_out;
    logic [31:0]      w_t;
    logic [31:0]      w_new;
    logic [10:0]      w_slot_lsb;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (if_kx.start && (if_kx.size != AES_RSVD)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                w_step = 1'b1;
                if (r_i == r_last_i) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_nk_req = nk_of(if_kx.size);
    assign w_nr_req = nr_of(if_kx.size);

    always_comb begin
        for (int m = 0; m < 8; m++) begin
            w_key_w[m] = if_kx.key[255 - 32*m -: 32];
        end
    end

    // Window slot 0 holds w[i-1]; slot Nk-1 holds w[i-Nk].
    assign w_prev      = r_win[0];
    assign w_old       = r_win[3'(r_nk - 4'd1)];
    assign w_rcon_step = (r_wrap == 3'd0);
    assign w_sub_in    = w_rcon_step ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .i_in  (w_sub_in[8*g +: 8]),
            .o_out (w_sub_out[8*g +: 8])
        );
    end

    always_comb begin
        if (w_rcon_step) begin
            w_t = w_sub_out ^ {r_rcon, 24'h000000};
        end else if ((r_nk == 4'd8) && (r_wrap == 3'd4)) begin
            w_t = w_sub_out;
        end else begin
            w_t = w_prev;
        end
    end

    assign w_new = w_old ^ w_t;

    // Word i lives in round key i/4, with word 0 of each key in the top 32 bits.
    assign w_slot_lsb = {r_i[5:2], 7'd0} + {4'd0, ~r_i[1:0], 5'd0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nk         <= 4'd0;
            r_nr         <= 4'd0;
            r_nr_out     <= 4'd0;
            r_i          <= 6'd0;
            r_last_i     <= 6'd0;
            r_wrap       <= 3'd0;
            r_rcon       <= 8'h00;
            r_round_keys <= '0;
            r_keys_valid <= 1'b0;
            r_done       <= 1'b0;
            for (int j = 0; j < 8; j++) begin
                r_win[j] <= 32'h0;
            end
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_nk         <= w_nk_req;
                r_nr         <= w_nr_req;
                r_nr_out     <= 4'd0;
                r_last_i     <= {w_nr_req, 2'b11};
                r_i          <= {2'b00, w_nk_req};
                r_wrap       <= 3'd0;
                r_rcon       <= 8'h01;
                r_keys_valid <= 1'b0;
                r_round_keys <= '0;
                for (int j = 0; j < 8; j++) begin
                    if (j < int'(w_nk_req)) begin
                        r_win[j] <= w_key_w[3'(w_nk_req - 4'd1 - 4'(j))];
                        r_round_keys[128*(j/4) + 32*(3 - (j%4)) +: 32] <= w_key_w[j];
                    end else begin
                        r_win[j] <= 32'h0;
                    end
                end
            end else if (w_step) begin
                r_round_keys[w_slot_lsb +: 32] <= w_new;
                r_win[0] <= w_new;
                for (int j = 1; j < 8; j++) begin
                    r_win[j] <= r_win[j-1];
                end
                r_i    <= r_i + 6'd1;
                r_wrap <= (r_wrap == 3'(r_nk - 4'd1)) ? 3'd0 : r_wrap + 3'd1;
                if (w_rcon_step) begin
                    r_rcon <= xtime(r_rcon);
                end
                if (w_last) begin
                    r_keys_valid <= 1'b1;
                    r_nr_out     <= r_nr;
                end
            end
        end
    end

    assign if_kx.busy       = (r_state == ST_EXPAND);
    assign if_kx.done       = r_done;
    assign if_kx.keys_valid = r_keys_valid;
    assign if_kx.nr         = r_nr_out;
    assign if_kx.round_keys = r_round_keys;
    assign if_kx.state_dbg  = r_state;

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: word-level key-schedule model checked every cycle, plus FIPS-197 literals.
module tb_aes_key_expander;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_key_expander_if kx();

    aes_key_expander dut (
        .clk   (clk),
        .rst   (rst),
        .if_kx (kx)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  sbox_t [256];
    logic [31:0] m_sched [60];
    int          m_written = 0;
    int          m_t = 0;
    int          m_nk = 4;
    int          m_nr = 10;
    bit          m_exp = 0;
    bit          m_done = 0;
    bit          m_valid = 0;
    logic [3:0]  m_nr_out = 4'd0;
    int          kv_low_cnt = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (16'(a) << k);
        for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h11b << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Textbook FIPS-197 KeyExpansion over an array, using mod arithmetic directly.
    task automatic build_sched(input logic [255:0] k);
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) m_sched[i] = 32'h0;
        for (int i = 0; i < m_nk; i++) m_sched[i] = k[255 - 32*i -: 32];
        for (int i = m_nk; i < m_t; i++) begin
            tmp = m_sched[i-1];
            if (i % m_nk == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (m_nk == 8 && i % m_nk == 4) begin
                tmp = sub_word(tmp);
            end
            m_sched[i] = m_sched[i-m_nk] ^ tmp;
        end
    endtask

    function automatic logic [127:0] exp_rk(input int r);
        logic [127:0] v;
        v = '0;
        for (int q = 0; q < 4; q++) begin
            if (4*r + q < m_written) v[127 - 32*q -: 32] = m_sched[4*r + q];
        end
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_exp = 0; m_done = 0; m_valid = 0; m_nr_out = 4'd0; m_written = 0;
        end else begin
            m_done = 0;
            if (m_exp) begin
                m_written++;
                if (m_written == m_t) begin
                    m_exp = 0; m_done = 1; m_valid = 1; m_nr_out = 4'(m_nr);
                end
            end else if (kx.start && kx.size != 2'b11) begin
                m_nk = (kx.size == 2'b00) ? 4 : (kx.size == 2'b01) ? 6 : 8;
                m_nr = m_nk + 6;
                m_t  = 4 * (m_nr + 1);
                build_sched(kx.key);
                m_written = m_nk; m_exp = 1; m_valid = 0; m_nr_out = 4'd0;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 256'(kx.busy), 256'(m_exp));
        chk("done", 256'(kx.done), 256'(m_done));
        chk("keys_valid", 256'(kx.keys_valid), 256'(m_valid));
        chk("nr", 256'(kx.nr), 256'(m_nr_out));
        for (int r = 0; r <= MAX_ROUNDS; r++) begin
            chk($sformatf("rk%0d", r), 256'(kx.round_keys[128*r +: 128]), 256'(exp_rk(r)));
        end
        if (!kx.keys_valid) kv_low_cnt++;
    end

    task automatic pulse_start(input logic [255:0] k, input logic [1:0] s);
        kx.key   = k;
        kx.size  = s;
        kx.start = 1'b1;
        @(posedge clk);
        #2;
        kx.start = 1'b0;
    endtask

    // Counts edges after the start edge until done; optionally fires a stray start mid-run.
    task automatic wait_done(input int exp_edges, input string name, input int spur_at);
        bit found;
        found = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #2;
            kx.start = (n == spur_at);
            if (n == spur_at) begin
                for (int q = 0; q < 8; q++) kx.key[32*q +: 32] = $urandom;
                kx.size = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            if (kx.done) begin
                chk({name, "_done_edge"}, 256'(n), 256'(exp_edges));
                found = 1;
                break;
            end
        end
        kx.start = 1'b0;
        chk({name, "_done_seen"}, 256'(found), 256'd1);
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int q = 0; q < 8; q++) k[32*q +: 32] = $urandom;
        return k;
    endfunction

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, 256'(kx.busy), 256'd0);
        chk({name, "_done"}, 256'(kx.done), 256'd0);
        chk({name, "_kv"}, 256'(kx.keys_valid), 256'd0);
        chk({name, "_nr"}, 256'(kx.nr), 256'd0);
        for (int r = 0; r <= MAX_ROUNDS; r++) begin
            chk({name, "_rk"}, 256'(kx.round_keys[128*r +: 128]), 256'd0);
        end
    endtask

    initial begin
        logic [255:0] k;
        int s;
        int edges;
        build_sbox();
        kx.start = 1'b0;
        kx.key   = '0;
        kx.size  = 2'b00;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #2;

        // FIPS-197 AES-128; low key bits are junk and must be ignored
        k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        k[127:0] = rand_key()[127:0];
        pulse_start(k, 2'b00);
        wait_done(40, "fips128", 0);
        chk("fips128_nr", 256'(kx.nr), 256'd10);
        chk("fips128_w4_model", 256'(m_sched[4]), 256'h a0fafe17);
        chk("fips128_w4", 256'(kx.round_keys[128*1 + 96 +: 32]), 256'h a0fafe17);
        chk("fips128_rk10", 256'(kx.round_keys[128*10 +: 128]), 256'h d014f9a8c9ee2589e13f0cc8b6630ca6);
        for (int r = 11; r <= 14; r++) begin
            chk("fips128_high_zero", 256'(kx.round_keys[128*r +: 128]), 256'd0);
        end

        // reserved size in IDLE is dropped
        pulse_start(rand_key(), 2'b11);
        @(negedge clk);
        chk("rsvd_busy", 256'(kx.busy), 256'd0);
        chk("rsvd_kv", 256'(kx.keys_valid), 256'd1);

        // FIPS-197 AES-192 with a stray start mid-run
        k = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        k[63:0] = rand_key()[63:0];
        @(posedge clk);
        #2;
        pulse_start(k, 2'b01);
        wait_done(46, "fips192", 17);
        chk("fips192_nr", 256'(kx.nr), 256'd12);
        chk("fips192_rk12", 256'(kx.round_keys[128*12 +: 128]), 256'h a4970a331a78dc09c418c271e3a41d5d);

        // FIPS-197 AES-256
        k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        pulse_start(k, 2'b10);
        wait_done(52, "fips256", 0);
        chk("fips256_nr", 256'(kx.nr), 256'd14);
        chk("fips256_rk14_model", 256'({m_sched[56], m_sched[57], m_sched[58], m_sched[59]}),
            256'h 24fc79ccbf0979e9371ac23c6d68de36);
        chk("fips256_rk14", 256'(kx.round_keys[128*14 +: 128]), 256'h 24fc79ccbf0979e9371ac23c6d68de36);

        // AES-128 then a start issued in the done cycle
        k = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        pulse_start(k, 2'b00);
        wait_done(40, "b2b_first", 0);
        chk("b2b_rk10", 256'(kx.round_keys[128*10 +: 128]), 256'h 13111d7fe3944a17f307a78b4d2b30c5);
        kv_low_cnt = 0;
        pulse_start(rand_key(), 2'b00);
        wait_done(40, "b2b_second", 0);
        chk("b2b_kv_low_cycles", 256'(kv_low_cnt), 256'd40);

        // asynchronous reset at E20 of an AES-256 run
        pulse_start(rand_key(), 2'b10);
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        pulse_start(k, 2'b10);
        wait_done(52, "post_rst256", 0);
        chk("post_rst_rk14", 256'(kx.round_keys[128*14 +: 128]), 256'h 24fc79ccbf0979e9371ac23c6d68de36);

        // randomized runs, mixed sizes, stray starts, variable gaps
        for (int run = 0; run < 10; run++) begin
            s = $urandom_range(0, 2);
            edges = (s == 0) ? 40 : (s == 1) ? 46 : 52;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #2;
            end
            pulse_start(rand_key(), 2'(s));
            wait_done(edges, $sformatf("rand%0d", run), ($urandom_range(0, 1) == 1) ? $urandom_range(1, edges - 2) : 0);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
